// File: rtl/seq_tx_pkg.sv
// Shared types and constants for the serial pattern transmitter and its benches.
package seq_tx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Default stimulus pattern for the 1101 sequence detector path.
   localparam logic [3:0] DEFAULT_PAT = 4'b1101;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter with enable and zero flag; load takes priority over enable.
module seq_down_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] q,
   output logic         zero
);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)      q <= '0;
      else if (load) q <= load_val;
      else if (en)   q <= q - 1'b1;
   end

   assign zero = (q == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: MSB-first shift-out with repeats and zero gaps.
// Define SEQ_TX_ASSERT_EN to enable FSM legality assertions.
module seq_pattern_tx
   import seq_tx_pkg::*;
#(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8,
   parameter int GAP_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [PAT_W-1:0] pattern,
   input  logic [CNT_W-1:0] repeat_cnt,
   input  logic [GAP_W-1:0] gap_len,
   input  logic             abort,
   output logic             sout,
   output logic             sout_valid,
   output logic             frame_last,
   output logic             done,
   output logic             busy
);

   localparam int                 IDX_W   = $clog2(PAT_W);
   localparam logic [IDX_W-1:0]   IDX_MAX = IDX_W'(PAT_W - 1);

   state_t             state;
   logic [PAT_W-1:0]   pat_reg;
   logic [GAP_W-1:0]   gap_reg;
   logic [IDX_W-1:0]   bit_idx, bit_dec;
   logic [CNT_W-1:0]   rep_left;
   logic [GAP_W-1:0]   gap_cnt;
   logic               bit_zero, rep_zero, gap_zero;
   logic               hs, run, pat_end, last_rep, gap_one;
   logic               bit_load, bit_en, rep_en, gap_load, gap_en;

   // abort only steers the busy states; in IDLE it is ignored.
   assign hs       = (state == IDLE) && start_valid;
   assign run      = !abort;
   assign last_rep = (rep_left == CNT_W'(1));
   assign gap_one  = (gap_cnt == GAP_W'(1));
   assign pat_end  = (state == SHIFT) && bit_zero && run;
   assign bit_dec  = bit_idx - 1'b1;

   assign bit_load = (hs && repeat_cnt != '0)
                   || (pat_end && !last_rep && gap_reg == '0)
                   || ((state == GAP) && run && gap_one);
   assign bit_en   = (state == SHIFT) && run && !bit_zero;
   assign rep_en   = pat_end && !last_rep && !rep_zero;
   assign gap_load = pat_end && !last_rep && gap_reg != '0;
   assign gap_en   = (state == GAP) && run && !gap_zero;

   seq_down_counter #(.W(IDX_W)) u_bit_cnt (
      .clk(clk), .rst(rst), .load(bit_load), .en(bit_en),
      .load_val(IDX_MAX), .q(bit_idx), .zero(bit_zero)
   );

   seq_down_counter #(.W(CNT_W)) u_rep_cnt (
      .clk(clk), .rst(rst), .load(hs), .en(rep_en),
      .load_val(repeat_cnt), .q(rep_left), .zero(rep_zero)
   );

   seq_down_counter #(.W(GAP_W)) u_gap_cnt (
      .clk(clk), .rst(rst), .load(gap_load), .en(gap_en),
      .load_val(gap_reg), .q(gap_cnt), .zero(gap_zero)
   );

   // Outputs are registered: each branch sets what the next cycle must show.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         pat_reg     <= '0;
         gap_reg     <= '0;
         start_ready <= 1'b1;
         sout        <= 1'b0;
         sout_valid  <= 1'b0;
         frame_last  <= 1'b0;
         done        <= 1'b0;
         busy        <= 1'b0;
      end else begin
         sout       <= 1'b0;
         sout_valid <= 1'b0;
         frame_last <= 1'b0;
         done       <= 1'b0;
         if (state != IDLE && abort) begin
            state       <= IDLE;
            start_ready <= 1'b1;
            busy        <= 1'b0;
         end else begin
            case (state)
               IDLE: if (start_valid) begin
                  pat_reg     <= pattern;
                  gap_reg     <= gap_len;
                  start_ready <= 1'b0;
                  busy        <= 1'b1;
                  if (repeat_cnt == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state      <= SHIFT;
                     sout       <= pattern[PAT_W-1];
                     sout_valid <= 1'b1;
                  end
               end
               SHIFT: begin
                  if (!bit_zero) begin
                     sout       <= pat_reg[bit_dec];
                     sout_valid <= 1'b1;
                     frame_last <= last_rep && (bit_dec == '0);
                  end else if (last_rep) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else if (gap_reg == '0) begin
                     sout       <= pat_reg[PAT_W-1];
                     sout_valid <= 1'b1;
                  end else begin
                     state <= GAP;
                  end
               end
               GAP: if (gap_one) begin
                  state      <= SHIFT;
                  sout       <= pat_reg[PAT_W-1];
                  sout_valid <= 1'b1;
               end
               DONE: begin
                  state       <= IDLE;
                  start_ready <= 1'b1;
                  busy        <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef SEQ_TX_ASSERT_EN
   state_t prev_state;

   function automatic logic legal_step(state_t from, state_t to);
      case (from)
         IDLE:    return to != GAP;
         SHIFT:   return 1'b1;
         GAP:     return to != DONE;
         DONE:    return to == IDLE;
         default: return 1'b0;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) prev_state <= IDLE;
      else      prev_state <= state;
   end

   always @(posedge clk) begin
      if (rst) begin
         assert (legal_step(prev_state, state))
            else $error("illegal transition: current=%s next=%s", prev_state.name(), state.name());
         assert (int'(bit_idx) < PAT_W)
            else $error("bit_idx out of range: current=%s next=%s", prev_state.name(), state.name());
         assert (!sout_valid || state == SHIFT)
            else $error("sout_valid outside SHIFT: current=%s next=%s", prev_state.name(), state.name());
      end
   end
`endif

endmodule
